tpu_host_loader: RTL and testbench

- Host-side initiator for the TPU pin protocol.
- Pulls bytes from a valid/ready stream and drives them onto the TPU data pins (ui_in) with matching command codes on uio_in[7:5], in this order: weights, then inputs, then instructions, then the start command.
- After start, waits a programmable latency and captures result bytes from uo_out into an output stream.
- Used in the FPGA/test-harness wrapper that sits in front of the TPU top.

---
 rtl/tpu_pkg.sv | 26 ++
 rtl/tpu_pin_skew.sv | 30 +++
 rtl/tpu_host_loader.sv | 163 ++++++++++++++++
 tb/tb_tpu_host_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU pin protocol: opcodes, loader states and the uio field layout.
package tpu_pkg;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OPC_NOP   = 3'b000;
   localparam opcode_t OPC_W     = 3'b001;
   localparam opcode_t OPC_INP   = 3'b010;
   localparam opcode_t OPC_INS   = 3'b011;
   localparam opcode_t OPC_START = 3'b100;

   // Bit position of the opcode field within tpu_uio_in; bits below it are a reserved address.
   localparam int unsigned OPC_LSB = 5;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_INP,
      LOAD_INS,
      START,
      WAIT,
      CAPTURE,
      DONE
   } loader_state_t;

endpackage

// File: rtl/tpu_pin_skew.sv
// Pin-side timing for the TPU: the opcode is registered once, the data byte twice, so each
// byte reaches tpu_ui_in one cycle after its opcode reaches tpu_uio_in.
module tpu_pin_skew
   import tpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opc,
   input  logic       data_vld,
   input  logic [7:0] data,
   output logic [7:0] tpu_ui_in,
   output logic [7:0] tpu_uio_in
);

   logic [7:0] data_q;

   // Opcode and byte are captured together; the byte waits one extra stage before the pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tpu_uio_in <= 8'h00;
         data_q     <= 8'h00;
         tpu_ui_in  <= 8'h00;
      end else begin
         tpu_uio_in <= 8'(opc) << OPC_LSB;
         data_q     <= data_vld ? data : 8'h00;
         tpu_ui_in  <= data_q;
      end
   end

endmodule

// File: rtl/tpu_host_loader.sv
// Host-side loader: streams weights, inputs and instructions onto the TPU pins, issues START,
// waits a fixed latency and captures the result bytes into an output stream.
module tpu_host_loader
   import tpu_pkg::*;
#(
   parameter int unsigned N_W     = 4,
   parameter int unsigned N_INP   = 4,
   parameter int unsigned N_INS   = 16,
   parameter int unsigned N_OUT   = 4,
   parameter int unsigned OUT_DLY = 8,
   parameter int unsigned CW      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic [7:0] tpu_ui_in,
   output logic [7:0] tpu_uio_in,
   input  logic [7:0] tpu_uo_out,
   output logic [7:0] m_data,
   output logic       m_valid,
   output logic       busy,
   output logic       done
);

   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] NW_C    = CW'(N_W);
   localparam logic [CW-1:0] NINP_C  = CW'(N_INP);
   localparam logic [CW-1:0] NINS_C  = CW'(N_INS);
   localparam logic [CW-1:0] NOUT_C  = CW'(N_OUT);
   localparam logic [CW-1:0] DLY_C   = CW'(OUT_DLY);

   // Empty phases are skipped by resolving each successor at elaboration time.
   localparam loader_state_t AFTER_INP   = (N_INS != 0) ? LOAD_INS : START;
   localparam loader_state_t AFTER_W     = (N_INP != 0) ? LOAD_INP : AFTER_INP;
   localparam loader_state_t FIRST_PHASE = (N_W != 0) ? LOAD_W : AFTER_W;
   localparam loader_state_t AFTER_START = (N_OUT != 0) ? WAIT : DONE;

   loader_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   opcode_t       opc;
   logic          accept;
   opcode_t       phase_opc;
   logic [CW-1:0] phase_n;
   loader_state_t phase_next;

   assign cnt_inc = cnt_q + CNT_ONE;

   // State and the shared phase counter; the counter is cleared on every phase change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Opcode, byte count and successor of the current LOAD phase.
   always_comb begin
      phase_opc  = OPC_NOP;
      phase_n    = NW_C;
      phase_next = AFTER_W;
      case (state_q)
         LOAD_W: begin
            phase_opc  = OPC_W;
            phase_n    = NW_C;
            phase_next = AFTER_W;
         end
         LOAD_INP: begin
            phase_opc  = OPC_INP;
            phase_n    = NINP_C;
            phase_next = AFTER_INP;
         end
         LOAD_INS: begin
            phase_opc  = OPC_INS;
            phase_n    = NINS_C;
            phase_next = START;
         end
         default: ;
      endcase
   end

   // Next state and stream/handshake outputs. Counters leave their phase on reaching the
   // terminal value, so they never advance past it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opc     = OPC_NOP;
      accept  = 1'b0;
      s_ready = 1'b0;
      m_valid = 1'b0;
      m_data  = 8'h00;
      done    = 1'b0;
      busy    = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (go) begin
               state_d = FIRST_PHASE;
               cnt_d   = '0;
            end
         end
         LOAD_W, LOAD_INP, LOAD_INS: begin
            s_ready = 1'b1;
            if (s_valid) begin
               accept = 1'b1;
               opc    = phase_opc;
               if (cnt_inc == phase_n) begin
                  state_d = phase_next;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         START: begin
            opc     = OPC_START;
            state_d = AFTER_START;
            cnt_d   = '0;
         end
         WAIT: begin
            // First WAIT cycle is the cycle START is visible on the pins.
            if (cnt_inc == DLY_C) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         CAPTURE: begin
            m_valid = 1'b1;
            m_data  = tpu_uo_out;
            if (cnt_inc == NOUT_C) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   tpu_pin_skew u_pin_skew (
      .clk        (clk),
      .reset      (reset),
      .opc        (opc),
      .data_vld   (accept),
      .data       (s_data),
      .tpu_ui_in  (tpu_ui_in),
      .tpu_uio_in (tpu_uio_in)
   );

endmodule

// File: tb/tb_tpu_host_loader.sv
// Bench for tpu_host_loader: two configurations, directed programs, timed scoreboard queues.
module tb_tpu_host_loader;

   localparam int A_NW = 2, A_NINP = 2, A_NINS = 2, A_NOUT = 3, A_DLY = 4;
   localparam int B_NW = 2, B_NINP = 0, B_NINS = 2, B_NOUT = 0, B_DLY = 1;

   typedef struct {
      int         at;
      logic [7:0] val;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        go;
   logic        sel;
   logic        s_valid;
   logic [7:0]  s_data;
   logic [7:0]  tpu_uo_out;
   int unsigned cyc = 0;

   logic [7:0] a_ui, a_uio, a_md, b_ui, b_uio, b_md;
   logic       a_rdy, a_mv, a_busy, a_done, b_rdy, b_mv, b_busy, b_done;
   logic [7:0] o_ui, o_uio, o_md;
   logic       o_rdy, o_mv, o_busy, o_done;

   logic [7:0] bytes_tbl [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

   ent_t opc_q[$];
   ent_t ui_q[$];
   ent_t m_q[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign tpu_uo_out = 8'hA0 + cyc[7:0];

   tpu_host_loader #(
      .N_W(A_NW), .N_INP(A_NINP), .N_INS(A_NINS), .N_OUT(A_NOUT), .OUT_DLY(A_DLY), .CW(8)
   ) dut_a (
      .clk        (clk),
      .reset      (reset),
      .go         (go & ~sel),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (a_rdy),
      .tpu_ui_in  (a_ui),
      .tpu_uio_in (a_uio),
      .tpu_uo_out (tpu_uo_out),
      .m_data     (a_md),
      .m_valid    (a_mv),
      .busy       (a_busy),
      .done       (a_done)
   );

   tpu_host_loader #(
      .N_W(B_NW), .N_INP(B_NINP), .N_INS(B_NINS), .N_OUT(B_NOUT), .OUT_DLY(B_DLY), .CW(8)
   ) dut_b (
      .clk        (clk),
      .reset      (reset),
      .go         (go & sel),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (b_rdy),
      .tpu_ui_in  (b_ui),
      .tpu_uio_in (b_uio),
      .tpu_uo_out (tpu_uo_out),
      .m_data     (b_md),
      .m_valid    (b_mv),
      .busy       (b_busy),
      .done       (b_done)
   );

   assign o_ui   = sel ? b_ui   : a_ui;
   assign o_uio  = sel ? b_uio  : a_uio;
   assign o_md   = sel ? b_md   : a_md;
   assign o_rdy  = sel ? b_rdy  : a_rdy;
   assign o_mv   = sel ? b_mv   : a_mv;
   assign o_busy = sel ? b_busy : a_busy;
   assign o_done = sel ? b_done : a_done;

   task automatic chk(input string tag, input int j, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, j, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] phase_of(input int idx, input int nw, input int ninp);
      if (idx < nw) return 3'b001;
      else if (idx < nw + ninp) return 3'b010;
      else return 3'b011;
   endfunction

   // One full program: go in cycle 0, then per cycle compare, then drive the next cycle.
   task automatic run_prog(input string name, input logic s, input logic [31:0] vpat,
                           input int go2_at);
      int nw, ninp, nb, nout, dly, left, done_cyc, base, dones;
      logic [7:0] e_uio, e_ui, e_md;
      logic       e_mv;
      nw       = s ? B_NW : A_NW;
      ninp     = s ? B_NINP : A_NINP;
      nb       = nw + ninp + (s ? B_NINS : A_NINS);
      nout     = s ? B_NOUT : A_NOUT;
      dly      = s ? B_DLY : A_DLY;
      left     = nb;
      done_cyc = 1000;
      dones    = 0;
      opc_q.delete();
      ui_q.delete();
      m_q.delete();
      sel     = s;
      base    = int'(cyc);
      go      = 1'b1;
      s_valid = 1'b1;   // offered while idle; must not be consumed
      s_data  = 8'hEE;
      for (int j = 1; j <= done_cyc + 1 && j < 100; j++) begin
         tick();
         e_uio = 8'h00;
         e_ui  = 8'h00;
         e_md  = 8'h00;
         e_mv  = 1'b0;
         if (opc_q.size() > 0 && opc_q[0].at == j) e_uio = opc_q.pop_front().val;
         if (ui_q.size() > 0 && ui_q[0].at == j) e_ui = ui_q.pop_front().val;
         if (m_q.size() > 0 && m_q[0].at == j) begin
            e_md = m_q.pop_front().val;
            e_mv = 1'b1;
         end
         chk({name, " uio"}, j, 32'(o_uio), 32'(e_uio));
         chk({name, " ui"}, j, 32'(o_ui), 32'(e_ui));
         chk({name, " m_valid"}, j, 32'(o_mv), 32'(e_mv));
         chk({name, " m_data"}, j, 32'(o_md), 32'(e_md));
         chk({name, " s_ready"}, j, 32'(o_rdy), 32'(left > 0));
         chk({name, " busy"}, j, 32'(o_busy), 32'(j < done_cyc));
         chk({name, " done"}, j, 32'(o_done), 32'(j == done_cyc));
         if (o_done === 1'b1) dones++;
         go = (j == go2_at);
         if (left > 0) begin
            if (vpat[j-1]) begin
               s_valid = 1'b1;
               s_data  = bytes_tbl[nb-left];
               opc_q.push_back('{j + 1, {phase_of(nb - left, nw, ninp), 5'b0}});
               ui_q.push_back('{j + 2, bytes_tbl[nb-left]});
               left--;
               if (left == 0) begin
                  opc_q.push_back('{j + 2, 8'h80});
                  if (nout == 0) begin
                     done_cyc = j + 2;
                  end else begin
                     for (int i = 0; i < nout; i++) begin
                        m_q.push_back('{j + 2 + dly + i, 8'(8'hA0 + base + j + 2 + dly + i)});
                     end
                     done_cyc = j + 2 + dly + nout;
                  end
               end
            end else begin
               s_valid = 1'b0;
               s_data  = 8'hEE;
            end
         end else begin
            s_valid = 1'b1;
            s_data  = 8'hEE;
         end
      end
      chk({name, " done pulses"}, done_cyc, 32'(dones), 32'd1);
      chk({name, " scoreboard drained"}, done_cyc,
          32'(opc_q.size() + ui_q.size() + m_q.size()), 32'd0);
      go      = 1'b0;
      s_valid = 1'b0;
   endtask

   initial begin
      sel     = 1'b0;
      go      = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      reset   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // go while reset is asserted must be ignored
      go = 1'b1;
      tick();
      chk("reset a uio", 0, 32'(a_uio), 32'd0);
      chk("reset a ui", 0, 32'(a_ui), 32'd0);
      chk("reset a s_ready", 0, 32'(a_rdy), 32'd0);
      chk("reset a busy", 0, 32'(a_busy), 32'd0);
      chk("reset a m_valid", 0, 32'(a_mv), 32'd0);
      chk("reset b busy", 0, 32'(b_busy), 32'd0);
      chk("reset b done", 0, 32'(b_done), 32'd0);
      go = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("go under reset a busy", 0, 32'(a_busy), 32'd0);
      chk("go under reset b busy", 0, 32'(b_busy), 32'd0);

      run_prog("basic", 1'b0, 32'hFFFF_FFFF, -1);
      run_prog("stall", 1'b0, 32'hFFFF_FFF5, -1);
      run_prog("skip", 1'b1, 32'hFFFF_FFFF, -1);
      run_prog("gobusy", 1'b0, 32'hFFFF_FFFF, 10);

      // Abort during LOAD_INP, then a fresh program must replay from LOAD_W.
      sel     = 1'b0;
      go      = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hEE;
      for (int j = 1; j <= 4; j++) begin
         tick();
         go     = 1'b0;
         s_data = bytes_tbl[j-1];
      end
      chk("abort pre uio", 4, 32'(a_uio), 32'h40);
      chk("abort pre ui", 4, 32'(a_ui), 32'h22);
      #2;
      reset = 1'b1;
      #1;
      chk("abort uio", 4, 32'(a_uio), 32'd0);
      chk("abort ui", 4, 32'(a_ui), 32'd0);
      chk("abort s_ready", 4, 32'(a_rdy), 32'd0);
      chk("abort busy", 4, 32'(a_busy), 32'd0);
      chk("abort m_valid", 4, 32'(a_mv), 32'd0);
      chk("abort done", 4, 32'(a_done), 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      s_valid = 1'b0;
      run_prog("replay", 1'b0, 32'hFFFF_FFFF, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
